// File: rtl/ring_buffer_tx.sv
// Transactional word FIFO (open/commit/rollback) between packet assemblers and SPI/MIL transmitters.
// Latency: push_done/pop_data/pop_done and all counters update 1 cycle after the request.
// Backpressure: none, because every request completes. A full buffer drops or overwrites and flags ovf. Define RING_BUFFER_OVF_CNT_EN for ovf_cnt.
module ring_buffer_tx #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 1,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_done,
    input  logic              pop_req,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_done,
    input  logic              open,
    input  logic              commit,
    input  logic              rollback,
    output logic [CNT_W-1:0]  mem_used,
    output logic [CNT_W-1:0]  pending,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf,
    output logic [15:0]       ovf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {TX_IDLE, TX_OPEN} tx_state_t;

    tx_state_t         state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, cm_ptr;
    logic [PTR_W-1:0]  rd_n, wr_n, cm_n, wr_adv;
    logic [CNT_W-1:0]  used_n, pend_n;
    logic              in_open, pop_ok, room, do_rb, do_cm, do_op;
    logic              wr_en, drop_oldest, push_lost;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_open     = (state == TX_OPEN);
        pop_ok      = pop_req && (mem_used != '0);
        // A successful pop in the same cycle frees a slot for the incoming word.
        room        = !full || pop_ok;
        do_rb       = in_open && rollback;
        do_cm       = in_open && commit && !rollback;
        do_op       = !in_open && open;
        wr_en       = 1'b0;
        drop_oldest = 1'b0;
        push_lost   = 1'b0;
        if (push_req) begin
            if (!in_open) begin
                if (room) begin
                    wr_en = 1'b1;
                end else if (OVERWRITE != 0) begin
                    wr_en       = 1'b1;
                    drop_oldest = 1'b1;
                    push_lost   = 1'b1;
                end else begin
                    push_lost = 1'b1;
                end
            end else if (!rollback) begin
                if (room) wr_en = 1'b1;
                else      push_lost = 1'b1;
            end
        end
        wr_adv = wr_en ? ptr_inc(wr_ptr) : wr_ptr;
        rd_n   = (pop_ok || drop_oldest) ? ptr_inc(rd_ptr) : rd_ptr;
        used_n = mem_used - CNT_W'(pop_ok);
        pend_n = pending;
        wr_n   = wr_adv;
        cm_n   = cm_ptr;
        if (!in_open) begin
            cm_n = wr_adv;
            if (wr_en && !drop_oldest) used_n = used_n + CNT_W'(1);
        end else if (do_rb) begin
            wr_n   = cm_ptr;
            pend_n = '0;
        end else begin
            pend_n = pending + CNT_W'(wr_en);
            if (do_cm) begin
                cm_n   = wr_adv;
                used_n = used_n + pend_n;
                pend_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TX_IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            mem_used  <= '0;
            pending   <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;  // the buffer really is empty after reset
            push_done <= 1'b0;
            pop_done  <= 1'b0;
            pop_data  <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            if (do_rb || do_cm) state <= TX_IDLE;
            else if (do_op)     state <= TX_OPEN;
            rd_ptr    <= rd_n;
            wr_ptr    <= wr_n;
            cm_ptr    <= cm_n;
            mem_used  <= used_n;
            pending   <= pend_n;
            full      <= ({1'b0, used_n} + {1'b0, pend_n}) == (CNT_W + 1)'(DEPTH);
            empty     <= (used_n == '0);
            push_done <= push_req;
            pop_done  <= pop_req;
            ovf       <= push_lost;
            unf       <= pop_req && !pop_ok;
            if (pop_req) pop_data <= pop_ok ? mem[rd_ptr] : '0;
        end
    end

`ifdef RING_BUFFER_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                  ovf_cnt <= '0;
        else if (push_lost && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_buffer_tx.sv
// Bench for ring_buffer_tx: DEPTH=16/OW=1, DEPTH=2/OW=1, DEPTH=2/OW=0 instances share one stimulus stream.
module tb_ring_buffer_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, push_req, pop_req, open, commit, rollback;
    logic [15:0] push_data;

    logic        push_done_a, pop_done_a, full_a, empty_a, ovf_a, unf_a;
    logic [15:0] pop_data_a, ovf_cnt_a;
    logic [4:0]  used_a, pend_a;
    logic        push_done_b, pop_done_b, full_b, empty_b, ovf_b, unf_b;
    logic [15:0] pop_data_b, ovf_cnt_b;
    logic [1:0]  used_b, pend_b;
    logic        push_done_c, pop_done_c, full_c, empty_c, ovf_c, unf_c;
    logic [15:0] pop_data_c, ovf_cnt_c;
    logic [1:0]  used_c, pend_c;

    ring_buffer_tx #(.DATA_W(16), .DEPTH(16), .OVERWRITE(1)) u_a (
        .clk(clk), .rst(rst), .push_req(push_req), .push_data(push_data), .push_done(push_done_a),
        .pop_req(pop_req), .pop_data(pop_data_a), .pop_done(pop_done_a), .open(open), .commit(commit),
        .rollback(rollback), .mem_used(used_a), .pending(pend_a), .full(full_a), .empty(empty_a),
        .ovf(ovf_a), .unf(unf_a), .ovf_cnt(ovf_cnt_a));
    ring_buffer_tx #(.DATA_W(16), .DEPTH(2), .OVERWRITE(1)) u_b (
        .clk(clk), .rst(rst), .push_req(push_req), .push_data(push_data), .push_done(push_done_b),
        .pop_req(pop_req), .pop_data(pop_data_b), .pop_done(pop_done_b), .open(open), .commit(commit),
        .rollback(rollback), .mem_used(used_b), .pending(pend_b), .full(full_b), .empty(empty_b),
        .ovf(ovf_b), .unf(unf_b), .ovf_cnt(ovf_cnt_b));
    ring_buffer_tx #(.DATA_W(16), .DEPTH(2), .OVERWRITE(0)) u_c (
        .clk(clk), .rst(rst), .push_req(push_req), .push_data(push_data), .push_done(push_done_c),
        .pop_req(pop_req), .pop_data(pop_data_c), .pop_done(pop_done_c), .open(open), .commit(commit),
        .rollback(rollback), .mem_used(used_c), .pending(pend_c), .full(full_c), .empty(empty_c),
        .ovf(ovf_c), .unf(unf_c), .ovf_cnt(ovf_cnt_c));

`ifdef RING_BUFFER_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: committed and pending words kept as plain ordered lists per instance.
    int          dep [3] = '{16, 2, 2};
    int          owr [3] = '{1, 1, 0};
    logic [15:0] mc [3][16];
    logic [15:0] mp [3][16];
    int nc [3], np [3], mop [3], mpd [3], movf [3], munf [3], mcnt [3], mpsd [3], mpdn [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            nc[k] = 0; np[k] = 0; mop[k] = 0; mpd[k] = 0; movf[k] = 0;
            munf[k] = 0; mcnt[k] = 0; mpsd[k] = 0; mpdn[k] = 0;
        end
    endtask

    task automatic shift_front(input int k);
        for (int i = 0; i < 15; i++) mc[k][i] = mc[k][i+1];
        nc[k]--;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            movf[k] = 0; munf[k] = 0;
            mpsd[k] = int'(push_req); mpdn[k] = int'(pop_req);
            if (pop_req) begin
                if (nc[k] > 0) begin
                    mpd[k] = int'(mc[k][0]);
                    shift_front(k);
                end else begin
                    munf[k] = 1; mpd[k] = 0;
                end
            end
            if (push_req) begin
                if (mop[k] == 0) begin
                    if (nc[k] + np[k] < dep[k]) begin
                        mc[k][nc[k]] = push_data; nc[k]++;
                    end else begin
                        movf[k] = 1;
                        if (owr[k] != 0) begin
                            shift_front(k);
                            mc[k][nc[k]] = push_data; nc[k]++;
                        end
                    end
                end else if (!rollback) begin
                    if (nc[k] + np[k] < dep[k]) begin
                        mp[k][np[k]] = push_data; np[k]++;
                    end else begin
                        movf[k] = 1;
                    end
                end
            end
            if (mop[k] != 0) begin
                if (rollback) begin
                    np[k] = 0; mop[k] = 0;
                end else if (commit) begin
                    for (int i = 0; i < np[k]; i++) mc[k][nc[k] + i] = mp[k][i];
                    nc[k] += np[k]; np[k] = 0; mop[k] = 0;
                end
            end else if (open) begin
                mop[k] = 1;
            end
            if (movf[k] != 0 && mcnt[k] < 65535) mcnt[k]++;
        end
    endtask

    typedef struct {
        logic [31:0] used, pend, full, empty, pd, pdn, psd, ovf, unf, cnt;
    } obs_t;

    function automatic obs_t get_obs(input int k);
        obs_t o;
        case (k)
            0: o = '{32'(used_a), 32'(pend_a), 32'(full_a), 32'(empty_a), 32'(pop_data_a),
                     32'(pop_done_a), 32'(push_done_a), 32'(ovf_a), 32'(unf_a), 32'(ovf_cnt_a)};
            1: o = '{32'(used_b), 32'(pend_b), 32'(full_b), 32'(empty_b), 32'(pop_data_b),
                     32'(pop_done_b), 32'(push_done_b), 32'(ovf_b), 32'(unf_b), 32'(ovf_cnt_b)};
            default: o = '{32'(used_c), 32'(pend_c), 32'(full_c), 32'(empty_c), 32'(pop_data_c),
                     32'(pop_done_c), 32'(push_done_c), 32'(ovf_c), 32'(unf_c), 32'(ovf_cnt_c)};
        endcase
        return o;
    endfunction

    task automatic cmp_model(input int cyc);
        obs_t o;
        for (int k = 0; k < 3; k++) begin
            o = get_obs(k);
            chk($sformatf("rnd%0d[%0d].mem_used", cyc, k), o.used, nc[k]);
            chk($sformatf("rnd%0d[%0d].pending", cyc, k), o.pend, np[k]);
            chk($sformatf("rnd%0d[%0d].full", cyc, k), o.full, 32'(nc[k] + np[k] == dep[k]));
            chk($sformatf("rnd%0d[%0d].empty", cyc, k), o.empty, 32'(nc[k] == 0));
            chk($sformatf("rnd%0d[%0d].pop_data", cyc, k), o.pd, mpd[k]);
            chk($sformatf("rnd%0d[%0d].pop_done", cyc, k), o.pdn, mpdn[k]);
            chk($sformatf("rnd%0d[%0d].push_done", cyc, k), o.psd, mpsd[k]);
            chk($sformatf("rnd%0d[%0d].ovf", cyc, k), o.ovf, movf[k]);
            chk($sformatf("rnd%0d[%0d].unf", cyc, k), o.unf, munf[k]);
            chk($sformatf("rnd%0d[%0d].ovf_cnt", cyc, k), o.cnt, CNT_EN ? mcnt[k] : 0);
        end
    endtask

    task automatic drive(input logic r, input logic pu, input logic [15:0] d, input logic po,
                         input logic op, input logic cm, input logic rb);
        rst = r; push_req = pu; push_data = d; pop_req = po; open = op; commit = cm; rollback = rb;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic pu; logic [15:0] d; logic po, op, cm, rb;
        int u, p; logic [15:0] pd; logic unf;
    } vec_t;
    vec_t tbl[$];
    vec_t v;

    function automatic vec_t mk(input logic pu, input logic [15:0] d, input logic po, input logic op,
                                input logic cm, input logic rb, input int u, input int p,
                                input logic [15:0] pd, input logic uf);
        vec_t r;
        r = '{pu, d, po, op, cm, rb, u, p, pd, uf};
        return r;
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        model_reset();
        cycle(); cycle();
        chk("reset.mem_used", 32'(used_a), 0);
        chk("reset.pending", 32'(pend_a), 0);
        chk("reset.empty", 32'(empty_a), 1);
        chk("reset.full", 32'(full_a), 0);
        chk("reset.pop_data", 32'(pop_data_a), 0);
        chk("reset.ovf_cnt", 32'(ovf_cnt_c), 0);

        // DEPTH=16 vectors: basic FIFO, open/commit, rollback with push, control priorities.
        tbl.push_back(mk(1, 16'hABCD, 0, 0, 0, 0, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(1, 16'h1234, 0, 0, 0, 0, 2, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 0, 16'hABCD, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h1234, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h1234, 0));
        tbl.push_back(mk(1, 16'h1111, 0, 0, 0, 0, 0, 1, 16'h1234, 0));
        tbl.push_back(mk(1, 16'h2222, 0, 0, 0, 0, 0, 2, 16'h1234, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 2, 16'h0000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 2, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 0, 16'h1111, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h2222, 0));
        tbl.push_back(mk(1, 16'h5555, 0, 0, 0, 0, 1, 0, 16'h2222, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 0, 16'h2222, 0));
        tbl.push_back(mk(1, 16'h6666, 0, 0, 0, 0, 1, 1, 16'h2222, 0));
        tbl.push_back(mk(1, 16'h7777, 0, 0, 0, 1, 1, 0, 16'h2222, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h5555, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h5555, 0));
        tbl.push_back(mk(1, 16'hAAAA, 0, 0, 0, 0, 0, 1, 16'h5555, 0));
        tbl.push_back(mk(1, 16'hBBBB, 0, 0, 1, 0, 2, 0, 16'h5555, 0));
        tbl.push_back(mk(1, 16'hCCCC, 0, 0, 1, 0, 3, 0, 16'h5555, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 3, 0, 16'h5555, 0));
        tbl.push_back(mk(1, 16'hDDDD, 0, 0, 0, 0, 3, 1, 16'h5555, 0));
        tbl.push_back(mk(1, 16'hEEEE, 0, 1, 0, 0, 3, 2, 16'h5555, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 3, 0, 16'h5555, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 2, 0, 16'hAAAA, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 0, 16'hBBBB, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'hCCCC, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'hCCCC, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(0, v.pu, v.d, v.po, v.op, v.cm, v.rb);
            cycle();
            chk($sformatf("vec%0d.mem_used", i), 32'(used_a), v.u);
            chk($sformatf("vec%0d.pending", i), 32'(pend_a), v.p);
            chk($sformatf("vec%0d.pop_data", i), 32'(pop_data_a), 32'(v.pd));
            chk($sformatf("vec%0d.pop_done", i), 32'(pop_done_a), 32'(v.po));
            chk($sformatf("vec%0d.push_done", i), 32'(push_done_a), 32'(v.pu));
            chk($sformatf("vec%0d.unf", i), 32'(unf_a), 32'(v.unf));
            chk($sformatf("vec%0d.ovf", i), 32'(ovf_a), 0);
            chk($sformatf("vec%0d.empty", i), 32'(empty_a), 32'(v.u == 0));
            chk($sformatf("vec%0d.full", i), 32'(full_a), 32'(v.u + v.p == 16));
        end

        // DEPTH=2 overflow: b overwrites oldest, c drops newest.
        drive(1, 0, 0, 0, 0, 0, 0); cycle();
        drive(0, 1, 16'hABCD, 0, 0, 0, 0); cycle();
        chk("ovf.push1.used_b", 32'(used_b), 1);
        chk("ovf.push1.used_c", 32'(used_c), 1);
        drive(0, 1, 16'hEF01, 0, 0, 0, 0); cycle();
        chk("ovf.push2.full_b", 32'(full_b), 1);
        chk("ovf.push2.full_c", 32'(full_c), 1);
        drive(0, 1, 16'h2345, 0, 0, 0, 0); cycle();
        chk("ovf.push3.ovf_b", 32'(ovf_b), 1);
        chk("ovf.push3.ovf_c", 32'(ovf_c), 1);
        chk("ovf.push3.used_b", 32'(used_b), 2);
        drive(0, 1, 16'h6789, 0, 0, 0, 0); cycle();
        chk("ovf.push4.ovf_b", 32'(ovf_b), 1);
        chk("ovf.push4.ovf_c", 32'(ovf_c), 1);
        drive(0, 0, 0, 1, 0, 0, 0); cycle();
        chk("ovf.pop1.data_b", 32'(pop_data_b), 32'h2345);
        chk("ovf.pop1.data_c", 32'(pop_data_c), 32'hABCD);
        chk("ovf.pop1.used_b", 32'(used_b), 1);
        drive(0, 0, 0, 1, 0, 0, 0); cycle();
        chk("ovf.pop2.data_b", 32'(pop_data_b), 32'h6789);
        chk("ovf.pop2.data_c", 32'(pop_data_c), 32'hEF01);
        chk("ovf.pop2.used_c", 32'(used_c), 0);
        chk("ovf.cnt_c", 32'(ovf_cnt_c), CNT_EN ? 2 : 0);

        // DEPTH=2 full: push and pop together, then reset in the middle of a transaction.
        drive(1, 0, 0, 0, 0, 0, 0); cycle();
        drive(0, 1, 16'h1001, 0, 0, 0, 0); cycle();
        drive(0, 1, 16'h1002, 0, 0, 0, 0); cycle();
        drive(0, 1, 16'h8888, 1, 0, 0, 0); cycle();
        chk("fullpp.data_b", 32'(pop_data_b), 32'h1001);
        chk("fullpp.ovf_b", 32'(ovf_b), 0);
        chk("fullpp.used_b", 32'(used_b), 2);
        chk("fullpp.data_c", 32'(pop_data_c), 32'h1001);
        drive(0, 0, 0, 1, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0, 0); cycle();
        drive(0, 1, 16'h3333, 0, 0, 0, 0); cycle();
        chk("midtx.pend_b", 32'(pend_b), 1);
        chk("midtx.full_b", 32'(full_b), 1);
        drive(1, 0, 0, 0, 0, 0, 0); cycle();
        chk("rstmid.used_b", 32'(used_b), 0);
        chk("rstmid.pend_b", 32'(pend_b), 0);
        chk("rstmid.full_b", 32'(full_b), 0);
        chk("rstmid.empty_b", 32'(empty_b), 1);
        chk("rstmid.pop_data_b", 32'(pop_data_b), 0);
        drive(0, 1, 16'h4444, 0, 0, 0, 0); cycle();
        chk("rstmid.idle_push_b", 32'(used_b), 1);

        // Randomized traffic against the reference model for all three instances.
        drive(1, 0, 0, 0, 0, 0, 0); cycle();
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 50, 16'($urandom),
                  $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 5);
            cycle();
            cmp_model(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
